// File: rtl/arbitro_pkg.sv
// Shared definitions for the functionality arbiter.
//   estado_t    : state encoding. Its value is also the Grant/Estado output
//                 pattern, so the outputs come straight from the state register.
//   FUNC_NEUTRO : function code that means "no request".
//   vence()     : decides a same-function conflict; returns the winning station index.
package arbitro_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      GRANT0 = 2'b01,
      GRANT1 = 2'b10,
      BOTH   = 2'b11
   } estado_t;

   localparam logic [2:0] FUNC_NEUTRO = 3'b000;

   // Higher user code wins. On a tie the station that did not own last wins.
   function automatic logic vence(input logic [2:0] user_a,
                                  input logic [2:0] user_b,
                                  input logic       last_owner);
      if (user_a > user_b) return 1'b0;
      if (user_b > user_a) return 1'b1;
      return ~last_owner;
   endfunction

endpackage

// File: rtl/arbitro_de_funcionalidade_contador_de_retencao.sv
// Saturating hold counter for the arbiter.
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   clear    : forces the count to 0 (takes priority over enable)
//   enable   : increments the count; it stops at all-ones
//   count    : current hold count
//   ge_min   : count >= MIN_HOLD
//   ge_max   : count >= MAX_GRANT. Always 0 when MAX_GRANT is 0.
module contador_de_retencao #(
   parameter int WIDTH     = 10,
   parameter int MIN_HOLD  = 4,
   parameter int MAX_GRANT = 1000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             enable,
   output logic [WIDTH-1:0] count,
   output logic             ge_min,
   output logic             ge_max
);

   localparam logic [WIDTH-1:0] MIN_C = WIDTH'(MIN_HOLD);
   localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_GRANT);
   localparam logic             MAX_ON = (MAX_GRANT != 0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

   assign ge_min = (count >= MIN_C);
   assign ge_max = MAX_ON & (count >= MAX_C);

endmodule

// File: rtl/arbitro_de_funcionalidade.sv
// Registered arbiter that shares the LED matrix, status LEDs and display
// between station 0 and station 1.
// State table:
//   state  | meaning
//   IDLE   | no station owns the outputs
//   GRANT0 | station 0 owns the outputs alone
//   GRANT1 | station 1 owns the outputs alone
//   BOTH   | the stations request different functions and run concurrently
// Ports:
//   Clock, Reset   : clock and asynchronous active-high reset
//   User0, Func0   : station 0 user code (priority) and function request
//   User1, Func1   : station 1 user code (priority) and function request
//   Grant          : per-station ownership; drives the output mux selects
//   Espera         : per-station "requesting but not granted"
//   GrantUser      : user code of the sole owner, 0 in IDLE or BOTH
//   Estado         : current state code
module arbitro_de_funcionalidade
   import arbitro_pkg::*;
#(
   parameter int MIN_HOLD  = 4,
   parameter int MAX_GRANT = 1000
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic [2:0] User0,
   input  logic [2:0] Func0,
   input  logic [2:0] User1,
   input  logic [2:0] Func1,
   output logic [1:0] Grant,
   output logic [1:0] Espera,
   output logic [2:0] GrantUser,
   output logic [1:0] Estado
);

   localparam int HOLD_TOP = (MIN_HOLD > MAX_GRANT) ? MIN_HOLD : MAX_GRANT;
   localparam int HOLD_W   = $clog2(HOLD_TOP + 1);

   estado_t           state, next_state;
   logic              last_owner;
   logic [2:0]        grant_user;
   logic [1:0]        espera;
   logic [1:0]        next_grant;
   logic [HOLD_W-1:0] hold;
   logic              ge_min, ge_max;
   logic              req0, req1, conflito, funcs_differ;
   logic              winner, entering;
   estado_t           arb_state, idle_next;

   assign req0         = (Func0 != FUNC_NEUTRO);
   assign req1         = (Func1 != FUNC_NEUTRO);
   assign conflito     = req0 & req1 & (Func0 == Func1);
   assign funcs_differ = req0 & req1 & (Func0 != Func1);

   // A sole requester wins outright; otherwise the conflict rule decides.
   assign winner    = (req0 ^ req1) ? req1 : vence(User0, User1, last_owner);
   assign arb_state = winner ? GRANT1 : GRANT0;

   // Release from a grant reuses this, so a new owner is picked with no idle cycle.
   always_comb begin
      idle_next = arb_state;
      if (!req0 && !req1)  idle_next = IDLE;
      else if (funcs_differ) idle_next = BOTH;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: next_state = idle_next;
         GRANT0: begin
            if (!req0)                                   next_state = idle_next;
            else if (funcs_differ)                       next_state = BOTH;
            else if (conflito && (User1 > User0) && ge_min) next_state = GRANT1;
            else if (conflito && ge_max)                 next_state = GRANT1;
         end
         GRANT1: begin
            if (!req1)                                   next_state = idle_next;
            else if (funcs_differ)                       next_state = BOTH;
            else if (conflito && (User0 > User1) && ge_min) next_state = GRANT0;
            else if (conflito && ge_max)                 next_state = GRANT0;
         end
         BOTH: begin
            if (!req0 && !req1)    next_state = IDLE;
            else if (!req0)        next_state = GRANT1;
            else if (!req1)        next_state = GRANT0;
            else if (Func0 == Func1) next_state = arb_state;
         end
         default: next_state = IDLE;
      endcase
   end

   assign entering   = (next_state != state);
   assign next_grant = next_state;

   contador_de_retencao #(
      .WIDTH     (HOLD_W),
      .MIN_HOLD  (MIN_HOLD),
      .MAX_GRANT (MAX_GRANT)
   ) u_hold (
      .clk    (Clock),
      .rst    (Reset),
      .clear  (entering),
      .enable (1'b1),
      .count  (hold),
      .ge_min (ge_min),
      .ge_max (ge_max)
   );

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state      <= IDLE;
         last_owner <= 1'b1;
         grant_user <= 3'b000;
         espera     <= 2'b00;
      end else begin
         state <= next_state;
         if (entering && (next_state == GRANT0)) last_owner <= 1'b0;
         if (entering && (next_state == GRANT1)) last_owner <= 1'b1;
         case (next_state)
            GRANT0:  grant_user <= User0;
            GRANT1:  grant_user <= User1;
            default: grant_user <= 3'b000;
         endcase
         espera <= {req1 & ~next_grant[1], req0 & ~next_grant[0]};
      end
   end

   assign Grant     = state;
   assign Estado    = state;
   assign GrantUser = grant_user;
   assign Espera    = espera;

endmodule
